// File: rtl/od_bus_pkg.sv
// Shared encodings for the open-drain two-wire bus master: command codes,
// engine states and the quarter-phase sequence of every bus step.
package od_bus_pkg;

  localparam logic [2:0] CMD_START = 3'd0;
  localparam logic [2:0] CMD_STOP  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;

  // Eight data bits plus the acknowledge bit.
  localparam int BITS_PER_BYTE = 9;

  typedef enum logic [1:0] {IDLE, START, STOP, BIT} state_e;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_e;

endpackage

// File: rtl/od_sync2.sv
// Two-flop synchronizer for an asynchronous pad readback; idles high like a
// pulled-up open-drain line.
module od_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep meta and q as two separate flops;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/od_bus_master.sv
// Byte-level open-drain two-wire bus master: runs START, STOP, WRITE and READ
// as sequences of four quarter phases, only ever pulling SCL/SDA low.
module od_bus_master #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] wr_data,
  input  logic       ack_tx,
  output logic [7:0] rd_data,
  output logic       ack_rx,
  output logic       done,
  output logic       scl_t,
  output logic       sda_t,
  input  logic       scl_in,
  input  logic       sda_in
);

  import od_bus_pkg::*;

  logic scl_s;
  logic sda_s;

  od_sync2 u_scl_sync (.clk(clk), .reset(reset), .d(scl_in), .q(scl_s));
  od_sync2 u_sda_sync (.clk(clk), .reset(reset), .d(sda_in), .q(sda_s));

  state_e           state, state_nxt;
  phase_e           phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       bit_idx, bit_nxt;
  logic [8:0]       tx_bits, tx_bits_nxt;
  logic [8:0]       rx_bits;
  logic             is_read;
  logic             nop_pend;
  logic             scl_nxt, sda_nxt;
  logic             accept, cnt_en, last_cnt, finish, sample;

  // A NOP parks in IDLE for one cycle with nop_pend set, so ready still drops.
  assign cmd_ready = (state == IDLE) && !nop_pend;
  assign accept    = cmd_valid && cmd_ready;
  assign last_cnt  = (cnt == CNT_W'(CLK_DIV - 1));
  // Q1 only advances while SCL is really high: that is clock stretching.
  assign cnt_en    = (phase != Q1) || scl_s;
  assign sample    = (state == BIT) && (phase == Q2) && last_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= Q0;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_bits  <= '1;
      nop_pend <= 1'b0;
      done     <= 1'b0;
      scl_t    <= 1'b1;
      sda_t    <= 1'b1;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      tx_bits  <= tx_bits_nxt;
      nop_pend <= accept && cmd[2];
      done     <= finish || nop_pend;
      scl_t    <= scl_nxt;
      sda_t    <= sda_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path through
  // the branches can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    cnt_nxt     = cnt;
    bit_nxt     = bit_idx;
    tx_bits_nxt = tx_bits;
    finish      = 1'b0;
    if (state == IDLE) begin
      if (accept && !cmd[2]) begin
        phase_nxt = Q0;
        cnt_nxt   = '0;
        bit_nxt   = '0;
        case (cmd)
          CMD_START: state_nxt = START;
          CMD_STOP:  state_nxt = STOP;
          CMD_WRITE: begin
            state_nxt   = BIT;
            tx_bits_nxt = {wr_data, 1'b1};
          end
          CMD_READ: begin
            state_nxt   = BIT;
            tx_bits_nxt = {8'hFF, ack_tx};
          end
          default: ;
        endcase
      end
    end else if (cnt_en) begin
      if (!last_cnt) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        cnt_nxt   = '0;
        phase_nxt = phase_e'(phase + 2'd1);
        if (phase == Q3) begin
          if (state == BIT && bit_idx != 4'(BITS_PER_BYTE - 1)) begin
            bit_nxt     = bit_idx + 4'd1;
            tx_bits_nxt = {tx_bits[7:0], 1'b1};
          end else begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
    end
  end

  // Line controls are registered from the phase being entered, so each edge
  // lands on the first cycle of its phase.
  always_comb begin
    scl_nxt = scl_t;
    sda_nxt = sda_t;
    case (state_nxt)
      START: begin
        case (phase_nxt)
          Q0: sda_nxt = 1'b1;
          Q1: scl_nxt = 1'b1;
          Q2: sda_nxt = 1'b0;
          Q3: scl_nxt = 1'b0;
        endcase
      end
      STOP: begin
        case (phase_nxt)
          Q0:      sda_nxt = 1'b0;
          Q1:      scl_nxt = 1'b1;
          Q2:      sda_nxt = 1'b1;
          default: ;
        endcase
      end
      BIT: begin
        case (phase_nxt)
          Q0: begin
            scl_nxt = 1'b0;
            sda_nxt = tx_bits_nxt[8];
          end
          Q1:      scl_nxt = 1'b1;
          Q3:      scl_nxt = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Receive path: nine samples per byte; the first eight are data, the last
  // is the acknowledge bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_bits <= '0;
      is_read <= 1'b0;
      rd_data <= 8'h00;
      ack_rx  <= 1'b0;
    end else begin
      if (accept) is_read <= (cmd == CMD_READ);
      if (sample) rx_bits <= {rx_bits[7:0], sda_s};
      if (finish && state == BIT) begin
        if (is_read) rd_data <= rx_bits[8:1];
        else         ack_rx  <= rx_bits[0];
      end
    end
  end

endmodule

// File: tb/tb_od_bus_master.sv
// Randomized bench for od_bus_master: a pulled-up open-drain bus with a slave
// model, checked against a transaction-level model of latency and bus bits.
module tb_od_bus_master;

  import od_bus_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int STRETCH = 50;
  localparam int TIMEOUT = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] wr_data;
  logic       ack_tx;
  logic [7:0] rd_data;
  logic       ack_rx;
  logic       done;
  logic       scl_t;
  logic       sda_t;
  logic       scl_in;
  logic       sda_in;

  int n_checks = 0;
  int n_errors = 0;

  // Slave and bus monitors.
  logic       slave_scl_low = 1'b0;
  logic       slave_sda_low;
  logic       slave_active  = 1'b0;
  logic [8:0] slave_pattern = '0;
  logic       stretch_arm   = 1'b0;
  int         scl_falls     = 0;
  int         slave_base    = 0;
  int         slave_bit;
  logic       samples [1024];
  int         sample_cnt    = 0;
  int         start_cnt     = 0;
  int         stop_cnt      = 0;

  // Transaction-level model state.
  logic       scl_low_m;
  logic [7:0] exp_rd;
  logic       exp_ack;

  assign scl_in = scl_t & ~slave_scl_low;
  assign sda_in = sda_t & ~slave_sda_low;

  always #5 clk = ~clk;

  od_bus_master #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .wr_data(wr_data), .ack_tx(ack_tx),
    .rd_data(rd_data), .ack_rx(ack_rx), .done(done),
    .scl_t(scl_t), .sda_t(sda_t), .scl_in(scl_in), .sda_in(sda_in)
  );

  // Slave bit k is the bit in progress after k SCL falls since arming.
  always_comb slave_bit = scl_falls - slave_base;

  always_comb begin
    slave_sda_low = 1'b0;
    if (slave_active && slave_bit >= 0 && slave_bit < 9)
      slave_sda_low = slave_pattern[4'(8 - slave_bit)];
  end

  // Slave moves SDA shortly after the master pulls SCL low.
  always @(negedge scl_t) begin
    #2;
    scl_falls++;
  end

  always @(negedge scl_t) begin
    #3;
    if (stretch_arm && slave_active && slave_bit == 3) begin
      slave_scl_low = 1'b1;
      @(posedge scl_t);
      // SCL stays low through STRETCH more clock edges than without a slave.
      repeat (STRETCH + 1) @(negedge clk);
      slave_scl_low = 1'b0;
    end
  end

  always @(posedge scl_in) begin
    samples[sample_cnt % 1024] = sda_in;
    sample_cnt++;
  end

  always @(negedge sda_in) if (scl_in === 1'b1) start_cnt++;
  always @(posedge sda_in) if (scl_in === 1'b1) stop_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command (caller is just after an edge with cmd_ready high) and
  // wait for done. Releasing SCL while it is held low costs two sync cycles.
  task automatic run_cmd(input logic [2:0] c, input logic [7:0] wd, input logic at,
                         input int extra, input bit keep_valid);
    int  exp_lat;
    int  lat;
    int  ready_bad;
    bit  seen;
    case (c)
      CMD_START, CMD_STOP: exp_lat = 4 * CLK_DIV + (scl_low_m ? 2 : 0);
      CMD_WRITE, CMD_READ: exp_lat = 36 * CLK_DIV + 2 * BITS_PER_BYTE;
      default:             exp_lat = 1;
    endcase
    exp_lat += extra;
    cmd       = c;
    wr_data   = wd;
    ack_tx    = at;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_accept", cmd_ready, 1'b0);
    check("done_after_accept", done, 1'b0);
    if (!keep_valid) cmd_valid = 1'b0;
    lat       = 0;
    ready_bad = 0;
    seen      = 1'b0;
    while (!seen && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
      else if (cmd_ready) ready_bad++;
    end
    check("done_seen", seen, 1'b1);
    check("latency", lat, exp_lat);
    check("ready_low_while_busy", ready_bad, 0);
    check("ready_at_done", cmd_ready, 1'b1);
    case (c)
      CMD_START, CMD_WRITE, CMD_READ: scl_low_m = 1'b1;
      CMD_STOP:                       scl_low_m = 1'b0;
      default: ;
    endcase
  endtask

  task automatic check_byte_bus(input string tag, input int base, input int st0,
                                input int sp0, input logic [8:0] exp_bits);
    logic [8:0] got_bits;
    got_bits = '0;
    for (int k = 0; k < 9; k++) got_bits[8-k] = samples[(base + k) % 1024];
    check({tag, "_scl_pulses"}, sample_cnt - base, 9);
    check({tag, "_sda_bits"}, got_bits, exp_bits);
    check({tag, "_no_start_stop"}, (start_cnt - st0) + (stop_cnt - sp0), 0);
  endtask

  task automatic do_write(input logic [7:0] wd, input logic slave_ack, input int extra);
    int base, st0, sp0;
    base = sample_cnt;
    st0  = start_cnt;
    sp0  = stop_cnt;
    slave_pattern = {8'h00, slave_ack};
    slave_base    = scl_falls;
    slave_active  = 1'b1;
    run_cmd(CMD_WRITE, wd, 1'b0, extra, 1'b0);
    slave_active  = 1'b0;
    exp_ack = ~slave_ack;
    check_byte_bus("write", base, st0, sp0, {wd, ~slave_ack});
    check("write_ack_rx", ack_rx, exp_ack);
    check("write_rd_data_kept", rd_data, exp_rd);
  endtask

  task automatic do_read(input logic [7:0] slave_byte, input logic at);
    int base, st0, sp0;
    base = sample_cnt;
    st0  = start_cnt;
    sp0  = stop_cnt;
    slave_pattern = {~slave_byte, 1'b0};
    slave_base    = scl_falls;
    slave_active  = 1'b1;
    run_cmd(CMD_READ, 8'h00, at, 0, 1'b0);
    slave_active  = 1'b0;
    exp_rd = slave_byte;
    check_byte_bus("read", base, st0, sp0, {slave_byte, at});
    check("read_rd_data", rd_data, exp_rd);
    check("read_ack_rx_kept", ack_rx, exp_ack);
  endtask

  initial begin
    int st0, sp0, dcount;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 3'd4;
    wr_data   = 8'h00;
    ack_tx    = 1'b0;
    scl_low_m = 1'b0;
    exp_rd    = 8'h00;
    exp_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_t", scl_t, 1'b1);
    check("rst_sda_t", sda_t, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_ack_rx", ack_rx, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // START from an idle bus.
    st0 = start_cnt;
    run_cmd(CMD_START, 8'h00, 1'b0, 0, 1'b0);
    check("start_condition", start_cnt - st0, 1);
    check("start_scl_low", scl_t, 1'b0);
    check("start_sda_low", sda_t, 1'b0);

    do_write(8'hA5, 1'b1, 0);
    do_write(8'h3C, 1'b0, 0);
    do_read(8'hC3, 1'b1);

    // Slave stretches SCL during bit 3.
    stretch_arm = 1'b1;
    do_write(8'h96, 1'b1, STRETCH);
    stretch_arm = 1'b0;

    sp0 = stop_cnt;
    run_cmd(CMD_STOP, 8'h00, 1'b0, 0, 1'b0);
    check("stop_condition", stop_cnt - sp0, 1);
    check("stop_scl_released", scl_t, 1'b1);
    check("stop_sda_released", sda_t, 1'b1);

    // cmd_valid held through done: the WRITE is taken in the done cycle.
    run_cmd(CMD_START, 8'h00, 1'b0, 0, 1'b1);
    do_write(8'($urandom), 1'($urandom), 0);

    for (int i = 0; i < 4; i++) begin
      do_write(8'($urandom), 1'($urandom), 0);
      do_read(8'($urandom), 1'($urandom));
    end

    // Reset during bit 4 of a READ.
    slave_pattern = {~8'h5A, 1'b0};
    slave_base    = scl_falls;
    slave_active  = 1'b1;
    cmd           = CMD_READ;
    ack_tx        = 1'b0;
    cmd_valid     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < TIMEOUT && slave_bit < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("reach_bit4", slave_bit >= 4, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_scl_t", scl_t, 1'b1);
    check("midrst_sda_t", sda_t, 1'b1);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    reset        = 1'b0;
    slave_active = 1'b0;
    scl_low_m    = 1'b0;
    exp_rd       = 8'h00;
    exp_ack      = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);

    run_cmd(3'd5, 8'hFF, 1'b1, 0, 1'b0);
    check("nop_rd_data", rd_data, exp_rd);
    check("nop_ack_rx", ack_rx, exp_ack);
    check("nop_scl_t", scl_t, 1'b1);
    check("nop_sda_t", sda_t, 1'b1);

    run_cmd(CMD_START, 8'h00, 1'b0, 0, 1'b0);
    run_cmd(CMD_STOP, 8'h00, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    check("done_single_cycle", done, 1'b0);
    check("final_scl_t", scl_t, 1'b1);
    check("final_sda_t", sda_t, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/od_bus_master.md
Name: od_bus_master

Overview:
- Byte-level open-drain two-wire (I2C-style) bus master, one per design.
- Produces the tristate controls that drive a pair of bidirectional pad buffers, one for SCL and one for SDA, and consumes their pad-readback outputs.
- Each pad buffer's data input is tied to 0, so the master only ever pulls a line low or releases it.
- Controlled by a processor port interface through a cmd_valid/cmd_ready handshake and a one-cycle done pulse.

Parameters:
- CLK_DIV, 4, clk cycles per quarter bit-period. Legal range 4..65535; bus bit rate = f_clk/(4*CLK_DIV) when there is no stretching.
- CNT_W, 16, width of the quarter-period counter. Must satisfy 2**CNT_W > CLK_DIV.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- reset  in  1  synchronous, active-high reset.
- cmd  in  3  command: 0 START, 1 STOP, 2 WRITE, 3 READ, 4-7 NOP.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; accepts a command when cmd_valid is also high.
- wr_data  in  8  byte for WRITE; captured at acceptance.
- ack_tx  in  1  ACK bit driven after a READ (0 = ACK); captured at acceptance.
- rd_data  out  8  byte received by the last READ.
- ack_rx  out  1  ACK bit sampled in the last WRITE.
- done  out  1  one-cycle pulse when a command completes.
- scl_t  out  1  SCL pad tristate control: 1 = release (high-Z), 0 = drive low.
- sda_t  out  1  SDA pad tristate control, same encoding.
- scl_in  in  1  SCL pad readback (asynchronous).
- sda_in  in  1  SDA pad readback (asynchronous).

Behaviour:
- Reset values: scl_t=1, sda_t=1, cmd_ready=1, done=0, rd_data=0x00, ack_rx=0, both synchronizer stages=1, state=IDLE.
- Reset mid-command: all of the above take effect on the next clk edge. Both lines are released and no done pulse is issued.
- Input synchronization: scl_in and sda_in each pass through 2 flops, giving scl_s and sda_s. All sampling uses the synchronized values.
- Acceptance: a command is accepted on the edge where cmd_valid=1 and cmd_ready=1. cmd_ready falls on that edge and stays low until the edge on which done rises. cmd_ready=1 and done=1 occur together for one cycle. A new command may be accepted in that cycle.
- NOP (cmd 4-7): done is asserted 1 cycle after acceptance. No line activity; rd_data and ack_rx are unchanged.
- Phases: every bus step has 4 quarter phases Q0..Q3. Each phase lasts CLK_DIV counted cycles.
  - Q0, Q2, Q3 count every cycle.
  - Q1 (SCL released) counts only cycles in which scl_s=1. This implements clock stretching, with no timeout.
- State machine: IDLE -> START | STOP | BIT -> IDLE. On completion the engine returns to IDLE with done=1.
- START (also repeated START):
  - Q0: sda_t=1, scl_t keeps its current value.
  - Q1: scl_t=1.
  - Q2: sda_t=0.
  - Q3: scl_t=0.
- STOP:
  - Q0: sda_t=0.
  - Q1: scl_t=1.
  - Q2: sda_t=1.
  - Q3: hold.
  - Ends with both lines released.
- WRITE: 9 BIT steps. Bits 0-7 are wr_data MSB first; bit 8 releases SDA.
- READ: 9 BIT steps. Bits 0-7 release SDA; bit 8 drives ack_tx.
- BIT step:
  - Q0: scl_t=0, and sda_t is set to the value being sent (1 = release).
  - Q1: scl_t=1.
  - Q2: hold; sda_s is sampled on the last cycle of Q2.
  - Q3: scl_t=0.
- Sampled values: the 8 sampled data bits of a READ shift MSB first into rd_data, which updates at done. The WRITE bit-8 sample goes to ack_rx.
- Latency from acceptance edge to done edge, with S = the number of Q1 cycles spent with scl_s=0:
  - START/STOP: 4*CLK_DIV + S.
  - WRITE/READ: 36*CLK_DIV + S.
- Boundaries:
  - The master never drives SDA high; a 1 is always sent by releasing the line.
  - A command issued before START is executed as specified, without protocol checking.
  - cmd_valid held high across done: the next command is accepted in the done cycle.

Decomposition:
- Package od_bus_pkg holds:
  - Command encodings CMD_START/STOP/WRITE/READ.
  - State enum {IDLE, START, STOP, BIT}.
  - Phase enum {Q0..Q3}.
  - Localparam BITS_PER_BYTE=9.
- Sub-module od_sync2: a 2-flop synchronizer with reset value 1, instantiated twice.

Test Plan:
- Reset with CLK_DIV=4, lines pulled up: all outputs at reset values. START accepted -> SDA falls while SCL high, then SCL falls; done 16 cycles after acceptance; cmd_ready=0 during the command.
- WRITE 0xA5, slave model ACKs -> SDA sampled at the 9 SCL high phases reads 1,0,1,0,0,1,0,1, then 0. ack_rx=0; done after 144+S cycles (S=2 from synchronizer delay per Q1 with a non-stretching slave).
- WRITE 0x3C with no slave -> ack_rx=1; the SDA pattern matches 0x3C.
- READ with ack_tx=1, slave drives 0xC3 -> rd_data=0xC3; SDA released at bit 8; done pulses once.
- Slave holds SCL low for 50 cycles during bit 3 of a WRITE -> the phase counter freezes and done is delayed by exactly 50 cycles. STOP then leaves scl_t=sda_t=1.
- reset asserted at bit 4 of a READ -> next edge scl_t=sda_t=1, cmd_ready=1, no done. A NOP accepted afterwards -> done 1 cycle later, rd_data unchanged.
